// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core types and sizes
package ooo_pkg;

    localparam int DEF_CDB_SIZE  = 2;
    localparam int DEF_ROB_DEPTH = 4;
    localparam int ROB_ENTRIES   = 2 ** DEF_ROB_DEPTH;
    localparam int ARCH_REG_W    = 5;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [ARCH_REG_W-1:0] rd_s;
        logic [31:0]           rd_v;
    } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// rtl/rob_if.sv - dispatch, CDB, lookup and commit bundle for the reorder buffer
interface rob_if #(
    parameter int CDB_SIZE  = 2,
    parameter int ROB_DEPTH = 4
);
    logic                                flush;
    logic                                dispatch_valid;
    logic [4:0]                          dispatch_rd_s;
    logic                                dispatch_ready;
    logic [ROB_DEPTH-1:0]                dispatch_rob;
    logic [CDB_SIZE-1:0]                 cdb_valid;
    logic [CDB_SIZE-1:0][31:0]           cdb_rd_v;
    logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]  cdb_rob;
    logic [ROB_DEPTH-1:0]                rs1_rob;
    logic [ROB_DEPTH-1:0]                rs2_rob;
    logic                                rs1_ready;
    logic                                rs2_ready;
    logic [31:0]                         rs1_v;
    logic [31:0]                         rs2_v;
    logic                                commit_valid;
    logic [4:0]                          commit_rd_s;
    logic [31:0]                         commit_rd_v;
    logic [ROB_DEPTH-1:0]                commit_rob;

    modport master (
        output flush, dispatch_valid, dispatch_rd_s, cdb_valid, cdb_rd_v, cdb_rob,
               rs1_rob, rs2_rob,
        input  dispatch_ready, dispatch_rob, rs1_ready, rs2_ready, rs1_v, rs2_v,
               commit_valid, commit_rd_s, commit_rd_v, commit_rob
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_rd_s, cdb_valid, cdb_rd_v, cdb_rob,
               rs1_rob, rs2_rob,
        output dispatch_ready, dispatch_rob, rs1_ready, rs2_ready, rs1_v, rs2_v,
               commit_valid, commit_rd_s, commit_rd_v, commit_rob
    );
endinterface

// File: rtl/rob.sv
// rtl/rob.sv - in-order retiring reorder buffer fed by the CDB, with operand bypass
module rob
    import ooo_pkg::*;
#(
    parameter int CDB_SIZE  = DEF_CDB_SIZE,
    parameter int ROB_DEPTH = DEF_ROB_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    rob_if.slave bus
);

    localparam int ENTRIES = 2 ** ROB_DEPTH;

    typedef logic [ROB_DEPTH:0]   ptr_t;
    typedef logic [ROB_DEPTH-1:0] tag_t;

    rob_entry_t entries [ENTRIES];
    ptr_t       head;
    ptr_t       tail;
    tag_t       head_idx;
    tag_t       tail_idx;
    logic       empty;
    logic       full;
    logic       dispatch_fire;
    logic       commit_fire;

    assign head_idx      = head[ROB_DEPTH-1:0];
    assign tail_idx      = tail[ROB_DEPTH-1:0];
    assign empty         = (head == tail);
    assign full          = (head[ROB_DEPTH] != tail[ROB_DEPTH]) && (head_idx == tail_idx);
    assign dispatch_fire = bus.dispatch_valid && !full;
    assign commit_fire   = !empty && entries[head_idx].done;

    // A CDB hit on a live entry overrides its stored value; later slots win.
    function automatic logic [32:0] lookup(input tag_t tag);
        logic [32:0] r;
        r = '0;
        if (entries[tag].valid) begin
            if (entries[tag].done) r = {1'b1, entries[tag].rd_v};
            for (int i = 0; i < CDB_SIZE; i++) begin
                if (bus.cdb_valid[i] && bus.cdb_rob[i] == tag) r = {1'b1, bus.cdb_rd_v[i]};
            end
        end
        return r;
    endfunction

    always_comb begin
        bus.dispatch_ready = !full;
        bus.dispatch_rob   = tail_idx;
        bus.commit_valid   = commit_fire;
        bus.commit_rd_s    = commit_fire ? entries[head_idx].rd_s : '0;
        bus.commit_rd_v    = commit_fire ? entries[head_idx].rd_v : '0;
        bus.commit_rob     = commit_fire ? head_idx : '0;
        {bus.rs1_ready, bus.rs1_v} = lookup(bus.rs1_rob);
        {bus.rs2_ready, bus.rs2_v} = lookup(bus.rs2_rob);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            if (dispatch_fire) begin
                entries[tail_idx] <= '{valid: 1'b1, done: 1'b0,
                                       rd_s: bus.dispatch_rd_s, rd_v: 32'd0};
                tail <= tail + 1'b1;
            end
            // Tail entry is never valid on a dispatch cycle, so CDB and dispatch cannot collide.
            for (int i = 0; i < CDB_SIZE; i++) begin
                if (bus.cdb_valid[i] && entries[bus.cdb_rob[i]].valid) begin
                    entries[bus.cdb_rob[i]].done <= 1'b1;
                    entries[bus.cdb_rob[i]].rd_v <= bus.cdb_rd_v[i];
                end
            end
            if (commit_fire) begin
                entries[head_idx].valid <= 1'b0;
                entries[head_idx].done  <= 1'b0;
                head <= head + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - self-checking bench for the reorder buffer
module tb_rob;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rob_if #(.CDB_SIZE(2), .ROB_DEPTH(4)) bus ();

    rob dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always @(negedge clk) begin
        if (rst_n && bus.cdb_valid[0] && bus.cdb_valid[1])
            assert (bus.cdb_rob[0] != bus.cdb_rob[1]) else $error("duplicate CDB tag");
    end

    typedef struct {
        int          tag;
        logic [4:0]  rd_s;
        bit          done;
        logic [31:0] v;
    } m_t;

    m_t q[$];
    int m_tail;

    task automatic idle();
        bus.flush = 0; bus.dispatch_valid = 0; bus.dispatch_rd_s = 0;
        bus.cdb_valid = 0; bus.cdb_rd_v = '0; bus.cdb_rob = '0;
        bus.rs1_rob = 0; bus.rs2_rob = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        #2 rst_n = 0;
        #3 rst_n = 1;
        tick();
        q.delete(); m_tail = 0;
    endtask

    task automatic dispatch_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.dispatch_valid = 1; bus.dispatch_rd_s = 5'(i + 1);
            tick();
        end
        bus.dispatch_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        checks++; if (bus.dispatch_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.dispatch_ready); end
        checks++; if (bus.dispatch_rob !== 4'd0) begin failures++; $display("FAIL reset_rob got=%0d exp=0", bus.dispatch_rob); end
        checks++; if ({bus.commit_valid, bus.commit_rd_s, bus.commit_rd_v, bus.commit_rob} !== '0) begin failures++; $display("FAIL reset_commit got=%0b/%0d/%h/%0d exp=0", bus.commit_valid, bus.commit_rd_s, bus.commit_rd_v, bus.commit_rob); end
        checks++; if ({bus.rs1_ready, bus.rs1_v, bus.rs2_ready, bus.rs2_v} !== '0) begin failures++; $display("FAIL reset_lookup got=%0b/%h exp=0", bus.rs1_ready, bus.rs1_v); end
        @(negedge clk); rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.dispatch_valid = 1; bus.dispatch_rd_s = 5;
        #1;
        checks++; if (bus.dispatch_rob !== 4'd0) begin failures++; $display("FAIL single_alloc_tag got=%0d exp=0", bus.dispatch_rob); end
        tick();
        bus.dispatch_valid = 0;
        bus.cdb_valid = 2'b01; bus.cdb_rob[0] = 0; bus.cdb_rd_v[0] = 32'hDEADBEEF;
        #1;
        checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", bus.commit_valid); end
        tick();
        bus.cdb_valid = 0;
        #1;
        checks++; if ({bus.commit_valid, bus.commit_rd_s, bus.commit_rd_v, bus.commit_rob} !== {1'b1, 5'd5, 32'hDEADBEEF, 4'd0}) begin failures++; $display("FAIL single_commit got=%0b/%0d/%h/%0d exp=1/5/deadbeef/0", bus.commit_valid, bus.commit_rd_s, bus.commit_rd_v, bus.commit_rob); end
        tick();
        #1;
        checks++; if (bus.commit_valid !== 1'b0 || bus.dispatch_rob !== 4'd1) begin failures++; $display("FAIL single_after got=%0b/%0d exp=0/1", bus.commit_valid, bus.dispatch_rob); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.dispatch_valid = 1; bus.dispatch_rd_s = 5'(i);
            #1;
            checks++; if (bus.dispatch_rob !== 4'(i) || bus.dispatch_ready !== 1'b1) begin failures++; $display("FAIL full_alloc%0d got=%0d/%0b exp=%0d/1", i, bus.dispatch_rob, bus.dispatch_ready, i); end
            tick();
        end
        #1;
        checks++; if (bus.dispatch_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", bus.dispatch_ready); end
        tick();
        bus.dispatch_valid = 0;
        bus.cdb_valid = 2'b10; bus.cdb_rob[1] = 0; bus.cdb_rd_v[1] = 32'd77;
        tick();
        bus.cdb_valid = 0;
        #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd_s !== 5'd0 || bus.dispatch_ready !== 1'b0) begin failures++; $display("FAIL full_commit got=%0b/%0d/%0b exp=1/0/0", bus.commit_valid, bus.commit_rd_s, bus.dispatch_ready); end
        tick();
        #1;
        checks++; if (bus.dispatch_ready !== 1'b1 || bus.dispatch_rob !== 4'd0) begin failures++; $display("FAIL full_wrap got=%0b/%0d exp=1/0", bus.dispatch_ready, bus.dispatch_rob); end
    endtask

    task automatic test_out_of_order();
        int exp_tag;
        do_reset();
        dispatch_n(3);
        for (int t = 2; t >= 0; t--) begin
            bus.cdb_valid = 2'b01; bus.cdb_rob[0] = 4'(t); bus.cdb_rd_v[0] = 32'(100 + t);
            #1;
            checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_early_commit tag=%0d got=%0b exp=0", t, bus.commit_valid); end
            tick();
        end
        bus.cdb_valid = 0;
        exp_tag = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rob !== 4'(exp_tag) || bus.commit_rd_v !== 32'(100 + exp_tag)) begin failures++; $display("FAIL ooo_commit%0d got=%0b/%0d/%0d exp=1/%0d/%0d", k, bus.commit_valid, bus.commit_rob, bus.commit_rd_v, exp_tag, 100 + exp_tag); end
            exp_tag++;
            tick();
        end
        #1;
        checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_drained got=%0b exp=0", bus.commit_valid); end
    endtask

    task automatic test_bypass();
        do_reset();
        dispatch_n(4);
        bus.cdb_valid = 2'b10; bus.cdb_rob[1] = 3; bus.cdb_rd_v[1] = 32'h1234;
        bus.rs1_rob = 3; bus.rs2_rob = 2;
        #1;
        checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_v !== 32'h1234) begin failures++; $display("FAIL bypass_same got=%0b/%h exp=1/1234", bus.rs1_ready, bus.rs1_v); end
        checks++; if (bus.rs2_ready !== 1'b0 || bus.rs2_v !== 32'h0) begin failures++; $display("FAIL bypass_notready got=%0b/%h exp=0/0", bus.rs2_ready, bus.rs2_v); end
        tick();
        bus.cdb_valid = 0;
        #1;
        checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_v !== 32'h1234) begin failures++; $display("FAIL bypass_stored got=%0b/%h exp=1/1234", bus.rs1_ready, bus.rs1_v); end
    endtask

    task automatic test_flush();
        do_reset();
        dispatch_n(4);
        bus.flush = 1; bus.dispatch_valid = 1;
        bus.cdb_valid = 2'b01; bus.cdb_rob[0] = 0; bus.cdb_rd_v[0] = 32'h55;
        tick();
        idle();
        #1;
        checks++; if (bus.dispatch_rob !== 4'd0 || bus.commit_valid !== 1'b0 || bus.dispatch_ready !== 1'b1) begin failures++; $display("FAIL flush_state got=%0d/%0b/%0b exp=0/0/1", bus.dispatch_rob, bus.commit_valid, bus.dispatch_ready); end
        checks++; if (bus.rs1_ready !== 1'b0) begin failures++; $display("FAIL flush_lookup got=%0b exp=0", bus.rs1_ready); end
    endtask

    task automatic test_async_reset();
        do_reset();
        dispatch_n(6);
        bus.cdb_valid = 2'b01; bus.cdb_rob[0] = 0; bus.cdb_rd_v[0] = 32'h99;
        tick();
        bus.cdb_valid = 0;
        bus.rs1_rob = 0;
        #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.rs1_ready !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b/%0b exp=1/1", bus.commit_valid, bus.rs1_ready); end
        #1 rst_n = 0;
        #1;
        checks++; if (bus.commit_valid !== 1'b0 || bus.dispatch_rob !== 4'd0 || bus.rs1_ready !== 1'b0 || bus.dispatch_ready !== 1'b1) begin failures++; $display("FAIL areset_now got=%0b/%0d/%0b/%0b exp=0/0/0/1", bus.commit_valid, bus.dispatch_rob, bus.rs1_ready, bus.dispatch_ready); end
        @(negedge clk); rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        bit          e_ready, e_commit, e_r1, e_r2, acc;
        logic [31:0] e_v1, e_v2;
        int          idx;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.flush          = ($urandom_range(0, 39) == 0);
            bus.dispatch_valid = ($urandom_range(0, 9) < 6);
            bus.dispatch_rd_s  = 5'($urandom);
            for (int s = 0; s < 2; s++) begin
                bus.cdb_valid[s] = $urandom_range(0, 1);
                bus.cdb_rd_v[s]  = $urandom;
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    bus.cdb_rob[s] = 4'(q[$urandom_range(0, q.size() - 1)].tag);
                else
                    bus.cdb_rob[s] = 4'($urandom);
            end
            if (bus.cdb_rob[1] == bus.cdb_rob[0]) bus.cdb_valid[1] = 0;
            bus.rs1_rob = 4'($urandom); bus.rs2_rob = 4'($urandom);
            #1;
            e_ready  = q.size() < 16;
            e_commit = q.size() > 0 && q[0].done;
            {e_r1, e_v1, e_r2, e_v2} = '0;
            foreach (q[k]) begin
                if (q[k].tag == int'(bus.rs1_rob)) begin
                    if (q[k].done) begin e_r1 = 1; e_v1 = q[k].v; end
                    for (int s = 0; s < 2; s++) if (bus.cdb_valid[s] && bus.cdb_rob[s] == bus.rs1_rob) begin e_r1 = 1; e_v1 = bus.cdb_rd_v[s]; end
                end
                if (q[k].tag == int'(bus.rs2_rob)) begin
                    if (q[k].done) begin e_r2 = 1; e_v2 = q[k].v; end
                    for (int s = 0; s < 2; s++) if (bus.cdb_valid[s] && bus.cdb_rob[s] == bus.rs2_rob) begin e_r2 = 1; e_v2 = bus.cdb_rd_v[s]; end
                end
            end
            checks++; if (bus.dispatch_ready !== e_ready || bus.dispatch_rob !== 4'(m_tail)) begin failures++; $display("FAIL rand_dispatch cyc=%0d got=%0b/%0d exp=%0b/%0d", cyc, bus.dispatch_ready, bus.dispatch_rob, e_ready, m_tail); end
            checks++;
            if (e_commit) begin
                if (bus.commit_valid !== 1'b1 || bus.commit_rob !== 4'(q[0].tag) || bus.commit_rd_s !== q[0].rd_s || bus.commit_rd_v !== q[0].v) begin failures++; $display("FAIL rand_commit cyc=%0d got=%0b/%0d/%0d/%h exp=1/%0d/%0d/%h", cyc, bus.commit_valid, bus.commit_rob, bus.commit_rd_s, bus.commit_rd_v, q[0].tag, q[0].rd_s, q[0].v); end
            end else if ({bus.commit_valid, bus.commit_rob, bus.commit_rd_s, bus.commit_rd_v} !== '0) begin
                failures++; $display("FAIL rand_nocommit cyc=%0d got=%0b/%0d exp=0", cyc, bus.commit_valid, bus.commit_rob);
            end
            checks++; if (bus.rs1_ready !== e_r1 || bus.rs1_v !== e_v1) begin failures++; $display("FAIL rand_rs1 cyc=%0d got=%0b/%h exp=%0b/%h", cyc, bus.rs1_ready, bus.rs1_v, e_r1, e_v1); end
            checks++; if (bus.rs2_ready !== e_r2 || bus.rs2_v !== e_v2) begin failures++; $display("FAIL rand_rs2 cyc=%0d got=%0b/%h exp=%0b/%h", cyc, bus.rs2_ready, bus.rs2_v, e_r2, e_v2); end
            if (bus.flush) begin
                q.delete(); m_tail = 0;
            end else begin
                acc = bus.dispatch_valid && e_ready;
                for (int s = 0; s < 2; s++) begin
                    if (bus.cdb_valid[s]) begin
                        idx = -1;
                        foreach (q[k]) if (q[k].tag == int'(bus.cdb_rob[s])) idx = k;
                        if (idx >= 0) begin q[idx].done = 1; q[idx].v = bus.cdb_rd_v[s]; end
                    end
                end
                if (e_commit) void'(q.pop_front());
                if (acc) begin
                    q.push_back('{tag: m_tail, rd_s: bus.dispatch_rd_s, done: 0, v: 0});
                    m_tail = (m_tail + 1) % 16;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_wrap();
        test_out_of_order();
        test_bypass();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer that sits directly downstream of the CDB.
- Allocates one entry per dispatched instruction, in program order.
- Captures results broadcast on every CDB slot and retires completed entries in order to the architectural register file.
- Provides operand-ready/value lookup, with same-cycle CDB bypass, for the rename/dispatch stage.

Parameters:
- CDB_SIZE, 2: number of CDB slots; one per reservation station.
- ROB_DEPTH, 4: ROB tag width in bits. Entry count is 2**ROB_DEPTH (16 by default).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; empties the ROB (mispredict recovery).
- dispatch_valid  input  1  dispatch stage requests an allocation.
- dispatch_rd_s  input  5  architectural destination register (x0 allowed).
- dispatch_ready  output  1  ROB not full; allocation accepted this cycle if dispatch_valid is high.
- dispatch_rob  output  ROB_DEPTH  tag of the entry being allocated (current tail).
- cdb_valid  input  1 x CDB_SIZE  CDB slot valid.
- cdb_rd_v  input  32 x CDB_SIZE  result value.
- cdb_rob  input  ROB_DEPTH x CDB_SIZE  destination ROB tag.
- rs1_rob, rs2_rob  input  ROB_DEPTH  tags looked up by rename.
- rs1_ready, rs2_ready  output  1  value available for the looked-up tag.
- rs1_v, rs2_v  output  32  value for the looked-up tag; 0 when not ready.
- commit_valid  output  1  head entry retires this cycle.
- commit_rd_s  output  5  head destination register.
- commit_rd_v  output  32  head result value.
- commit_rob  output  ROB_DEPTH  head tag.

Behaviour:
- Entry state: valid, done, rd_s[4:0], rd_v[31:0].
- Pointers: head and tail are ROB_DEPTH+1 bits wide, the MSB being a wrap bit.
  - empty: head == tail.
  - full: MSBs differ and low bits are equal.
  - Tags wrap from 2**ROB_DEPTH-1 to 0.
- Reset (async, rst_n=0): head=tail=0; all valid/done/rd_s/rd_v cleared. Outputs after reset: dispatch_ready=1, dispatch_rob=0, commit_valid=0, commit_rd_s=0, commit_rd_v=0, commit_rob=0, rsX_ready=0, rsX_v=0. Reset asserted mid-operation discards all entries immediately.
- Dispatch:
  - dispatch_ready = !full, combinational from registered pointers.
  - A freeing commit in the same cycle does NOT raise dispatch_ready.
  - On dispatch_valid && dispatch_ready: the entry at tail gets valid=1, done=0, rd_s=dispatch_rd_s; tail increments.
  - dispatch_valid while full is ignored; no state change.
- CDB capture: for each slot i with cdb_valid[i], if entry[cdb_rob[i]].valid then done=1 and rd_v=cdb_rd_v[i] at the edge.
  - Writes to invalid entries are dropped.
  - Two slots carrying the same tag in one cycle is illegal (bench asserts). The RTL lets the higher index win.
- Commit:
  - commit_valid = !empty && entry[head].done; it is combinational from registers.
  - commit_rd_s, commit_rd_v and commit_rob are driven from the head entry and are 0 when commit_valid=0.
  - On commit_valid: entry[head].valid and done clear; head increments.
  - Maximum one retirement per cycle.
  - CDB-to-commit latency is exactly 1 cycle. A CDB write to the head tag in cycle N commits in cycle N+1; there is no commit bypass.
  - Dispatch with rd_s=0 still allocates and commits. The regfile ignores the x0 write.
- Operand lookup (combinational, per rsX):
  - If any cdb_valid[i] has cdb_rob[i]==rsX_rob and the entry is valid: ready=1, v=cdb_rd_v[i] (same-cycle bypass).
  - Else if the entry is valid and done: ready=1, v=entry.rd_v.
  - Else: ready=0, v=0.
- Simultaneous dispatch + commit when full: commit proceeds; dispatch is not accepted (ready=0).
- Simultaneous dispatch + commit when empty: the new entry is not done, so no commit.
- Flush:
  - Priority over dispatch, CDB and commit in the same cycle.
  - Next state: head=tail=0; all valid/done cleared.
  - commit_valid is still driven combinationally from current state during the flush cycle.
  - The commit outputs must be ignored when flush=1; head does not advance.

Decomposition:
- Shared package ooo_pkg:
  - rob_entry_t struct {valid, done, rd_s, rd_v}.
  - localparam ROB_ENTRIES = 2**ROB_DEPTH.
  - ARCH_REG_W = 5.
- No sub-module needed. Pointer full/empty logic stays inline.

Test Plan:
- Reset then dispatch rd_s=5, CDB tag 0 value 0xDEADBEEF in the next cycle -> commit_valid=1 one cycle later with rd_s=5, rd_v=0xDEADBEEF, rob=0; head=1.
- Dispatch 16 entries (ROB_DEPTH=4) -> dispatch_ready=0 after the 16th. Complete tag 0, commit it -> dispatch_ready=1 next cycle; the next dispatch_rob=0 (wrap).
- Dispatch tags 0,1,2; CDB completes 2 then 1 then 0 -> no commit until tag 0 is done; then commits 0,1,2 on consecutive cycles.
- Lookup rs1_rob=3 while slot 1 broadcasts tag 3 value 0x1234 -> rs1_ready=1, rs1_v=0x1234 same cycle. Next cycle (no CDB): still ready=1, v=0x1234.
- 4 entries in flight, assert flush together with dispatch_valid and a CDB write -> next cycle: empty, dispatch_rob=0, commit_valid=0, dispatch_ready=1.
- Drop rst_n asynchronously mid-cycle with 6 entries live -> outputs go to their reset values immediately, without waiting for a clk edge.
